mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported backing memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (load/store). Sequences each access with a req/ack handshake on both sides.
//  Drives a pipeline stall while any access is outstanding. Sits between the pipeline and the memory.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width
//  CNT_W   16  width of wait-cycle counters (used only with ARB_PERF_EN)
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       asynchronous, active-high reset
//  if_req_i     in   1       fetch request; held until if_ack_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_rdata_o   out  DATA_W  fetched word; valid while if_ack_o=1
//  if_ack_o     out  1       one-cycle completion pulse to IF
//  dm_req_i     in   1       data request; held until dm_ack_o
//  dm_we_i      in   1       1=store, 0=load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data; valid while dm_ack_o=1
//  dm_ack_o     out  1       one-cycle completion pulse to MEM stage
//  mem_req_o    out  1       request to memory; held until mem_ack_i
//  mem_we_o     out  1       write enable to memory
//  mem_addr_o   out  ADDR_W  latched address
//  mem_wdata_o  out  DATA_W  latched write data
//  mem_rdata_i  in   DATA_W  memory read data; valid with mem_ack_i
//  mem_ack_i    in   1       memory completion; may arrive in the first mem_req_o cycle
//  stall_o      out  1       (if_req_i&~if_ack_o)|(dm_req_i&~dm_ack_o), combinational
// BEHAVIOUR
//  Reset: state=IDLE; mem_req_o, mem_we_o, if_ack_o and dm_ack_o are 0; mem_addr_o, mem_wdata_o,
//   if_rdata_o and dm_rdata_o are 0.
//  States:
//   IDLE: if dm_req_i, grant=DM; else if if_req_i, grant=IF. On a grant, latch addr/we/wdata
//    (IF latches we=0, wdata=0) and go to BUSY.
//   BUSY: mem_req_o=1 and all mem_* outputs stay stable. On mem_ack_i, register mem_rdata_i into
//    the granted rdata_o and go to DONE.
//   DONE: the granted ack_o is 1 for exactly this cycle. Requests are ignored here, so a
//    requester dropping req after its ack is never re-issued. Go to IDLE.
//  Latency: req seen in cycle 0 -> mem_req_o from cycle 1 -> ack_o at cycle 2+N, where N is the
//   number of memory wait cycles. Minimum spacing between back-to-back grants is 3 cycles.
//  Priority: DM strictly over IF, because the MEM stage is older. IF cannot starve because
//   stall_o freezes issue of new DM requests.
//  Simultaneous if_req_i and dm_req_i in IDLE: DM is served first. IF is granted in the IDLE
//   cycle following DM's DONE.
//  Request dropped during BUSY: the access still completes and ack pulses. Memory contents are
//   not rolled back.
//  mem_ack_i outside BUSY is ignored.
//  Reset asserted mid-access: immediate return to reset values. The in-flight memory access is
//   abandoned; memory must tolerate mem_req_o falling without ack.
//  rdata_o holds its last captured value after ack.
// CONFIGURATION
//  ARB_PERF_EN defined:
//   - Adds ports if_wait_cnt_o and dm_wait_cnt_o (out, CNT_W).
//   - Each counts cycles with req_i=1 and ack_o=0, saturating at all-ones. Reset to 0.
//  ARB_PERF_EN undefined: no counter ports or logic; behaviour otherwise identical.
// STRUCTURE
//  Package mem_arb_pkg holds:
//   - state enum: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
//   - grant encoding: GNT_IF=1'b0, GNT_DM=1'b1
//  Sub-module mem_arb_wait_counter: saturating CNT_W counter, instantiated twice, only under
//   ARB_PERF_EN.
// TESTING
//  1. IF only, zero-wait memory: if_req_i=1, if_addr_i=0x10, mem_ack_i in first mem_req_o cycle,
//     mem_rdata_i=0xDEADBEEF -> mem_addr_o=0x10, mem_we_o=0, if_ack_o pulse at cycle 2,
//     if_rdata_o=0xDEADBEEF.
//  2. Simultaneous: if_req_i (0x20) and dm_req_i (we=1, 0x80, wdata=0x55) -> first mem access is
//     we=1/0x80/0x55 and dm_ack_o pulses. IF access to 0x20 follows, if_ack_o 3 cycles after
//     dm_ack_o. stall_o=1 until if_ack_o.
//  3. Wait states: mem_ack_i delayed 3 cycles -> mem_req_o high 4 cycles, addr/we/wdata stable,
//     single ack pulse, stall_o high throughout.
//  4. Requester holds req one cycle past ack (DONE) -> no second mem_req_o.
//     Requester drops req during BUSY -> access still completes and ack pulses.
//  5. Reset in BUSY -> mem_req_o, acks and rdata 0 asynchronously. Late mem_ack_i after reset is
//     ignored. A fresh request then completes normally.
//  6. ARB_PERF_EN: scenario 2 with zero-wait memory -> dm_wait_cnt_o=2, if_wait_cnt_o=5.
//     Forcing an all-ones count -> the counter holds at all-ones.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state and grant encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Saturating wait-cycle counter; counts enabled cycles and holds at all-ones.
module mem_arb_wait_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
// Optional wait-cycle counters are built when ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
`ifdef ARB_PERF_EN
    output logic [CNT_W-1:0]  if_wait_cnt_o,
    output logic [CNT_W-1:0]  dm_wait_cnt_o,
`endif
    output logic [1:0]        dbg_state_o
);

    // Handshake: each requester holds req until its one-cycle ack; the memory
    // sees mem_req_o held with stable addr/we/wdata until mem_ack_i is sampled.

    state_t state, state_next;
    grant_t grant, grant_next;
    logic   start;
    logic   capture;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            grant <= GNT_IF;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    // DM wins ties: the MEM stage holds the older instruction.
    always_comb begin
        state_next = state;
        grant_next = grant;
        start      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req_i) begin
                    grant_next = GNT_DM;
                    start      = 1'b1;
                    state_next = BUSY;
                end else if (if_req_i) begin
                    grant_next = GNT_IF;
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (start) begin
            if (grant_next == GNT_DM) begin
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
            end else begin
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
            end
        end
    end

    // Read data is kept after ack until the same port's next completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else if (capture) begin
            if (grant == GNT_DM) begin
                dm_rdata_o <= mem_rdata_i;
            end else begin
                if_rdata_o <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = (state == BUSY);
    assign if_ack_o    = (state == DONE) && (grant == GNT_IF);
    assign dm_ack_o    = (state == DONE) && (grant == GNT_DM);
    assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);
    assign dbg_state_o = state;

`ifdef ARB_PERF_EN
    mem_arb_wait_counter #(.CNT_W(CNT_W)) u_if_wait (
        .clk (clk_i),
        .rst (rst_i),
        .en  (if_req_i & ~if_ack_o),
        .cnt (if_wait_cnt_o)
    );

    mem_arb_wait_counter #(.CNT_W(CNT_W)) u_dm_wait (
        .clk (clk_i),
        .rst (rst_i),
        .en  (dm_req_i & ~dm_ack_o),
        .cnt (dm_wait_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized accesses
// checked against a cycle-level transaction model. Perf checks build with ARB_PERF_EN.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall;
    logic [1:0]        dbg_state;
`ifdef ARB_PERF_EN
    logic [CNT_W-1:0]  if_wait_cnt;
    logic [CNT_W-1:0]  dm_wait_cnt;
    logic              sat_en;
    logic [2:0]        sat_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] last_if_rdata;
    logic [DATA_W-1:0] last_dm_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ack_o    (if_ack),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_ack_o    (dm_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_o     (stall),
`ifdef ARB_PERF_EN
        .if_wait_cnt_o (if_wait_cnt),
        .dm_wait_cnt_o (dm_wait_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

`ifdef ARB_PERF_EN
    mem_arb_wait_counter #(.CNT_W(3)) u_sat (
        .clk (clk),
        .rst (rst),
        .en  (sat_en),
        .cnt (sat_cnt)
    );
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_if_rdata = '0;
        last_dm_rdata = '0;
    endtask

    // Drives one or two concurrent requests and a memory with the given wait states.
    // Expected timing: first access has mem_req in cycles 1..1+w0 and ack at 2+w0;
    // a second (IF behind DM) has mem_req from ack0+2 and ack at ack0+3+w1.
    task automatic run_access(input bit do_if, input bit do_dm, input bit we,
                              input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                              input logic [DATA_W-1:0] wd, input int w_if, input int w_dm,
                              input bit drop_first, input bit use_fixed,
                              input logic [DATA_W-1:0] fixed_rdata);
        bit                acc_dm[2];
        logic              acc_we[2];
        logic [ADDR_W-1:0] acc_addr[2];
        logic [DATA_W-1:0] acc_wdata[2];
        int                acc_wait[2];
        int n_acc = 0, acc_idx = 0, busy_cnt = 0, req_cycles = 0, exp_req_cycles = 0;
        int ack0, ack1, exp_if_ack, exp_dm_ack, last_ack;
        logic [DATA_W-1:0] if_exp = '0, dm_exp = '0, rd;
        bit exp_stall, exp_mem_req;
        if (do_dm) begin
            acc_dm[n_acc] = 1'b1; acc_we[n_acc] = we; acc_addr[n_acc] = da;
            acc_wdata[n_acc] = wd; acc_wait[n_acc] = w_dm; n_acc++;
        end
        if (do_if) begin
            acc_dm[n_acc] = 1'b0; acc_we[n_acc] = 1'b0; acc_addr[n_acc] = ia;
            acc_wdata[n_acc] = '0; acc_wait[n_acc] = w_if; n_acc++;
        end
        ack0 = 2 + acc_wait[0];
        ack1 = (n_acc == 2) ? ack0 + 3 + acc_wait[1] : -1;
        exp_dm_ack = do_dm ? ack0 : -1;
        exp_if_ack = do_if ? (do_dm ? ack1 : ack0) : -1;
        last_ack = (n_acc == 2) ? ack1 : ack0;
        for (int k = 0; k < n_acc; k++) exp_req_cycles += acc_wait[k] + 1;

        for (int cyc = 0; cyc <= last_ack + 3; cyc++) begin
            @(posedge clk); #1;
            mem_ack  = 1'b0;
            if_addr  = ia;
            dm_addr  = da;
            dm_we    = we;
            dm_wdata = wd;
            dm_req = do_dm && (cyc <= exp_dm_ack) && !(drop_first && cyc >= 2);
            if_req = do_if && (cyc <= exp_if_ack) && !(drop_first && !do_dm && cyc >= 2);
            @(negedge clk);
            exp_stall = (if_req && cyc != exp_if_ack) || (dm_req && cyc != exp_dm_ack);
            exp_mem_req = (cyc >= 1 && cyc <= 1 + acc_wait[0]) ||
                          (n_acc == 2 && cyc >= ack0 + 2 && cyc <= ack0 + 2 + acc_wait[1]);
            check_eq("stall", stall, exp_stall);
            check_eq("mem_req", mem_req, exp_mem_req);
            check_eq("if_ack", if_ack, cyc == exp_if_ack);
            check_eq("dm_ack", dm_ack, cyc == exp_dm_ack);
            if (cyc == exp_if_ack) check_eq("if_rdata", if_rdata, if_exp);
            if (cyc == exp_dm_ack) check_eq("dm_rdata", dm_rdata, dm_exp);
            rd = use_fixed ? fixed_rdata : $urandom;
            mem_rdata = rd;
            if (mem_req) begin
                req_cycles++;
                if (acc_idx < n_acc) begin
                    check_eq("mem_addr", mem_addr, acc_addr[acc_idx]);
                    check_eq("mem_we", mem_we, acc_we[acc_idx]);
                    check_eq("mem_wdata", mem_wdata, acc_wdata[acc_idx]);
                    if (busy_cnt == acc_wait[acc_idx]) begin
                        mem_ack = 1'b1;
                        if (acc_dm[acc_idx]) dm_exp = rd;
                        else                 if_exp = rd;
                        acc_idx++;
                        busy_cnt = 0;
                    end else begin
                        busy_cnt++;
                    end
                end else begin
                    mem_ack = 1'b1;
                end
            end else begin
                // Stray acks outside an access must be ignored.
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        if (do_if) last_if_rdata = if_exp;
        if (do_dm) last_dm_rdata = dm_exp;
        @(negedge clk);
        check_eq("req_cycles", 64'(req_cycles), 64'(exp_req_cycles));
        check_eq("if_rdata_hold", if_rdata, last_if_rdata);
        check_eq("dm_rdata_hold", dm_rdata, last_dm_rdata);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        last_if_rdata = '0; last_dm_rdata = '0;
`ifdef ARB_PERF_EN
        sat_en = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_if_ack", if_ack, 1'b0);
        check_eq("rst_dm_ack", dm_ack, 1'b0);
        check_eq("rst_if_rdata", if_rdata, '0);
        check_eq("rst_dm_rdata", dm_rdata, '0);
        check_eq("rst_state", dbg_state, 2'd0);
        check_eq("rst_stall", stall, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // IF only, zero-wait memory
        run_access(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF);
        check_eq("s1_if_rdata", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: DM store first, IF fetch after
        reset_pulse();
        run_access(1, 1, 1, 32'h20, 32'h80, 32'h55, 0, 0, 0, 0, '0);
`ifdef ARB_PERF_EN
        check_eq("perf_dm_wait", dm_wait_cnt, 16'd2);
        check_eq("perf_if_wait", if_wait_cnt, 16'd5);
`endif

        // Wait states on both ports
        run_access(0, 1, 0, 32'h0, 32'h140, 32'h0, 0, 3, 0, 0, '0);
        run_access(1, 0, 0, 32'h44, 32'h0, 32'h0, 3, 0, 0, 0, '0);
        run_access(1, 1, 0, 32'h48, 32'h1c0, 32'h0, 2, 3, 0, 0, '0);

        // Requester drops req during BUSY
        run_access(0, 1, 1, 32'h0, 32'h200, 32'hCAFE, 0, 2, 1, 0, '0);
        run_access(1, 0, 0, 32'h300, 32'h0, 32'h0, 2, 0, 1, 0, '0);

        // Reset asserted mid-access, then a late ack
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h1234;
        @(posedge clk); #1;
        check_eq("pre_rst_busy", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_mem_req", mem_req, 1'b0);
        check_eq("async_rst_mem_we", mem_we, 1'b0);
        check_eq("async_rst_dm_ack", dm_ack, 1'b0);
        check_eq("async_rst_dm_rdata", dm_rdata, '0);
        check_eq("async_rst_if_rdata", if_rdata, '0);
        dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check_eq("late_ack_mem_req", mem_req, 1'b0);
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check_eq("late_ack_dm_ack", dm_ack, 1'b0);
        check_eq("late_ack_dm_rdata", dm_rdata, '0);
        check_eq("late_ack_state", dbg_state, 2'd0);
        last_if_rdata = '0; last_dm_rdata = '0;
        run_access(0, 1, 0, 32'h0, 32'h404, 32'h0, 0, 1, 0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit ri, rdm;
            ri  = 1'($urandom_range(0, 1));
            rdm = 1'($urandom_range(0, 1));
            if (!ri && !rdm) ri = 1'b1;
            run_access(ri, rdm, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 4), $urandom_range(0, 4),
                       1'($urandom_range(0, 1)), 0, '0);
        end

`ifdef ARB_PERF_EN
        // Saturation of a narrow counter
        reset_pulse();
        @(posedge clk); #1 sat_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 sat_en = 1'b1;
        check_eq("sat_count5", sat_cnt, 3'd5);
        repeat (5) @(posedge clk);
        #1 sat_en = 1'b0;
        check_eq("sat_hold", sat_cnt, 3'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
